// File: rtl/switch_egress_reader.sv
// switch_egress_reader: per-port egress FIFOs drained by Avalon-MM reads, with status and irq
module switch_egress_reader #(
    parameter int NUM_PORTS = 3,
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        chipselect,
    input  logic                        read,
    input  logic [3:0]                  address,
    output logic [31:0]                 readdata,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic                        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0]    mem [NUM_PORTS][DEPTH];
    logic [AW-1:0]        wr_ptr [NUM_PORTS];
    logic [AW-1:0]        rd_ptr [NUM_PORTS];
    logic [CW-1:0]        count [NUM_PORTS];
    logic [CW-1:0]        count_nxt [NUM_PORTS];
    logic [NUM_PORTS-1:0] empty, full, push, pop, uf_set, underflow, underflow_nxt;
    logic [31:0]          status, rd_nxt;
    logic                 acc, irq_nxt;

    always_comb begin
        acc     = chipselect && read;
        status  = '0;
        rd_nxt  = '0;
        irq_nxt = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            empty[p]       = count[p] == '0;
            full[p]        = count[p] == CW'(DEPTH);
            in_ready[p]    = !full[p];
            push[p]        = in_valid[p] && !full[p];
            pop[p]         = acc && address == 4'(p + 1) && !empty[p];
            uf_set[p]      = acc && address == 4'(p + 1) && empty[p];
            count_nxt[p]   = count[p] + CW'(push[p]) - CW'(pop[p]);
            irq_nxt        = irq_nxt || count_nxt[p] != '0;
            status[p]      = empty[p];
            status[8 + p]  = full[p];
            status[16 + p] = underflow[p];
            if (pop[p]) rd_nxt = mem[p][rd_ptr[p]];
        end
        if (address == 4'd0) rd_nxt = status;
        // a same-cycle underflow survives the clear-on-read of STATUS
        underflow_nxt = ((acc && address == 4'd0) ? '0 : underflow) | uf_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata  <= '0;
            irq       <= 1'b0;
            underflow <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            if (acc) readdata <= rd_nxt;
            irq       <= irq_nxt;
            underflow <= underflow_nxt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + AW'(1);
                if (pop[p]) rd_ptr[p] <= rd_ptr[p] + AW'(1);
                count[p] <= count_nxt[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_switch_egress_reader.sv
// tb_switch_egress_reader: table-driven vectors plus corner sequences, read data checked via a scoreboard queue
module tb_switch_egress_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic [3:0]  address = '0;
    logic [31:0] readdata;
    logic [2:0]  in_valid = '0;
    logic [95:0] in_data = '0;
    logic [2:0]  in_ready;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [2:0]  v;
        logic [31:0] d;
        logic        r;
        logic [3:0]  a;
        logic [31:0] e;
        logic [2:0]  rdy;
        logic        irq;
    } vec_t;

    switch_egress_reader #(.NUM_PORTS(3), .DEPTH(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .read(read),
        .address(address), .readdata(readdata), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // one bus cycle: optional pushes on ports in v, optional read of address a
    task automatic cyc(input logic [2:0] v, input logic [31:0] d, input logic r,
                       input logic [3:0] a, input logic [31:0] e, input string nm);
        @(negedge clk);
        in_valid   = v;
        in_data    = {3{d}};
        chipselect = r;
        read       = r;
        address    = a;
        if (r) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid   = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        if (r) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: scoreboard empty", nm);
            end else check(nm, readdata, exp_q.pop_front());
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
        cyc(3'b000, 32'h0, 1'b1, a, e, nm);
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{3'b000, 32'h0,  1'b1, 4'd0, 32'h0000_0007, 3'b111, 1'b0};
        vecs[1] = '{3'b001, 32'hA1, 1'b0, 4'd0, 32'h0,         3'b111, 1'b1};
        vecs[2] = '{3'b001, 32'hA2, 1'b0, 4'd0, 32'h0,         3'b111, 1'b1};
        vecs[3] = '{3'b000, 32'h0,  1'b1, 4'd1, 32'hA1,        3'b111, 1'b1};
        vecs[4] = '{3'b000, 32'h0,  1'b1, 4'd1, 32'hA2,        3'b111, 1'b0};
        vecs[5] = '{3'b000, 32'h0,  1'b1, 4'd0, 32'h0000_0007, 3'b111, 1'b0};
        vecs[6] = '{3'b000, 32'h0,  1'b1, 4'd3, 32'h0,         3'b111, 1'b0};
        vecs[7] = '{3'b000, 32'h0,  1'b1, 4'd0, 32'h0004_0007, 3'b111, 1'b0};
        vecs[8] = '{3'b000, 32'h0,  1'b1, 4'd0, 32'h0000_0007, 3'b111, 1'b0};

        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_in_ready", {29'h0, in_ready}, 32'h7);

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].a, vecs[i].e, $sformatf("vec%0d_rd", i));
            check($sformatf("vec%0d_rdy", i), {29'h0, in_ready}, {29'h0, vecs[i].rdy});
            check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].irq});
        end

        // fill port1, offer a fifth word while full, pop with it still held
        for (int i = 0; i < 4; i++) cyc(3'b010, 32'h10 + 32'(i), 1'b0, 4'd0, 32'h0, "fill");
        check("full_rdy", {29'h0, in_ready}, 32'h5);
        rd(4'd0, 32'h0000_0205, "full_status");
        cyc(3'b010, 32'h99, 1'b0, 4'd0, 32'h0, "held");
        cyc(3'b010, 32'h99, 1'b1, 4'd2, 32'h10, "full_pop");
        check("rdy_after_pop", {29'h0, in_ready}, 32'h7);
        rd(4'd2, 32'h11, "drain1");
        rd(4'd2, 32'h12, "drain2");
        rd(4'd2, 32'h13, "drain3");
        rd(4'd2, 32'h0, "drain_uf");
        check("drain_irq", {31'h0, irq}, 32'h0);
        rd(4'd0, 32'h0002_0007, "uf1_status");
        rd(4'd0, 32'h0000_0007, "uf1_cleared");

        // same-cycle push and pop on a one-word FIFO returns the old head
        cyc(3'b001, 32'hB5, 1'b0, 4'd0, 32'h0, "b5");
        cyc(3'b001, 32'hB0, 1'b1, 4'd1, 32'hB5, "pushpop");
        rd(4'd0, 32'h0000_0006, "pushpop_status");
        rd(4'd1, 32'hB0, "pushpop_next");
        rd(4'd0, 32'h0000_0007, "pushpop_empty");

        // empty FIFO with same-cycle push still underflows and keeps the word
        cyc(3'b100, 32'hC0, 1'b1, 4'd3, 32'h0, "nobypass");
        rd(4'd0, 32'h0004_0003, "nobypass_status");
        rd(4'd3, 32'hC0, "nobypass_word");
        rd(4'd12, 32'h0, "unmapped");

        // reset mid-stream discards buffered words
        cyc(3'b100, 32'hD1, 1'b0, 4'd0, 32'h0, "d1");
        cyc(3'b100, 32'hD2, 1'b0, 4'd0, 32'h0, "d2");
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_irq", {31'h0, irq}, 32'h0);
        check("midreset_rdy", {29'h0, in_ready}, 32'h7);
        @(negedge clk);
        reset = 1'b1;
        rd(4'd3, 32'h0, "post_reset_pop");
        rd(4'd0, 32'h0004_0007, "post_reset_status");
        rd(4'd0, 32'h0000_0007, "post_reset_clear");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
